mem_resp_queue: RTL and testbench

- Next-generation MEM stage. Replaces the single-entry "one load at a time" MEM register with an in-order queue of DEPTH entries.
- Up to DEPTH memory requests can be outstanding between EX and WB.
- Responses (data_ok/rdata) that arrive while WB stalls are buffered.
- After a pipeline flush, responses to requests already issued on the bus are counted and silently dropped.
- Sits between the EX stage (which issues addr to data-sram) and the WB stage. Also performs load-data alignment and extension.

---
 rtl/mem_resp_queue_if.sv | 42 ++++
 rtl/mem_resp_queue.sv | 167 ++++++++++++++++
 tb/tb_mem_resp_queue.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_queue_if.sv
// EX / WB / data-sram signal bundle for mem_resp_queue.
// master drives instructions and responses; slave is the queue.
interface mem_resp_queue_if #(
    parameter int DEPTH = 4,
    parameter int BUS_W = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_allowin;
    logic [BUS_W-1:0] in_bus;
    logic             in_req;
    logic             in_res_from_mem;
    logic [4:0]       in_load_op;
    logic [31:0]      in_result;
    logic             in_exc;
    logic             out_valid;
    logic             out_allowin;
    logic [BUS_W-1:0] out_bus;
    logic [31:0]      out_result;
    logic             out_exc;
    logic             data_ok;
    logic [31:0]      rdata;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_bus, in_req, in_res_from_mem,
        output in_load_op, in_result, in_exc, out_allowin,
        output data_ok, rdata,
        input  in_allowin, out_valid, out_bus, out_result,
        input  out_exc, count
    );

    modport slave (
        input  flush, in_valid, in_bus, in_req, in_res_from_mem,
        input  in_load_op, in_result, in_exc, out_allowin,
        input  data_ok, rdata,
        output in_allowin, out_valid, out_bus, out_result,
        output out_exc, count
    );
endinterface

// File: rtl/mem_resp_queue.sv
// In-order MEM-stage queue of outstanding loads with load alignment.
// MEM_RESP_BYPASS_EN: forward data_ok/rdata straight to a waiting head.
module mem_resp_queue #(
    parameter int DEPTH = 4,
    parameter int BUS_W = 64
) (
    input logic             clk,
    input logic             reset,
    mem_resp_queue_if.slave q
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

    typedef struct packed {
        logic [BUS_W-1:0] bus;
        logic             req;
        logic             mem;
        logic [4:0]       op;
        logic [31:0]      result;
        logic             exc;
        logic             has_data;
        logic [31:0]      data;
    } ent_t;

    ent_t          ent_q [DEPTH];
    ent_t          ent_d [DEPTH];
    logic [PW-1:0] head_ptr_q, head_ptr_d;
    logic [PW-1:0] tail_ptr_q, tail_ptr_d;
    logic [PW-1:0] resp_ptr, idx;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] owed_cnt;
    logic          owed_found, resp_hit, byp;
    logic          head_rdy, out_valid, in_allowin;
    logic          enq, deq, consumed;
    ent_t          head;
    logic [31:0]   head_data;

    function automatic logic [31:0] ld_ext(
        input logic [4:0]  op,
        input logic [1:0]  off,
        input logic [31:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        unique case (1'b1)
            op[1]:   r = {{24{b[7]}}, b};
            op[3]:   r = {24'b0, b};
            op[2]:   r = {{16{h[15]}}, h};
            op[4]:   r = {16'b0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // oldest entry still owed a response is where the next data_ok lands
    always_comb begin : scan
        resp_ptr   = head_ptr_q;
        idx        = head_ptr_q;
        owed_found = 1'b0;
        owed_cnt   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr_q + PW'(k);
            if (CW'(k) < count_q && ent_q[idx].req
                && !ent_q[idx].has_data) begin
                owed_cnt = owed_cnt + CW'(1);
                if (!owed_found) begin
                    owed_found = 1'b1;
                    resp_ptr   = idx;
                end
            end
        end
    end

    always_comb begin : head_sel
        head     = ent_q[head_ptr_q];
        resp_hit = q.data_ok && (discard_q == '0) && owed_found;
`ifdef MEM_RESP_BYPASS_EN
        byp      = resp_hit && (resp_ptr == head_ptr_q);
`else
        byp      = 1'b0;
`endif
        head_rdy   = !head.req || head.has_data || byp;
        head_data  = byp ? q.rdata : head.data;
        out_valid  = (count_q != '0) && head_rdy && !q.flush;
        deq        = out_valid && q.out_allowin;
        in_allowin = !q.flush
                  && (({1'b0, count_q} + {1'b0, discard_q}) < DEPTH_W);
        enq        = q.in_valid && in_allowin;
        consumed   = q.data_ok && ((discard_q != '0) || owed_found);
    end

    assign q.in_allowin = in_allowin;
    assign q.out_valid  = out_valid;
    assign q.out_bus    = head.bus;
    assign q.out_exc    = head.exc;
    assign q.out_result = head.mem
                        ? ld_ext(head.op, head.result[1:0], head_data)
                        : head.result;
    assign q.count      = count_q;

    always_comb begin : next_state
        ent_d      = ent_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        if (q.data_ok && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
        if (resp_hit && !(byp && deq)) begin
            ent_d[resp_ptr].has_data = 1'b1;
            ent_d[resp_ptr].data     = q.rdata;
        end
        if (q.flush) begin
            // killed loads still get answered on the bus; drop those later
            discard_d  = discard_q + owed_cnt - CW'(consumed);
            head_ptr_d = tail_ptr_q;
            count_d    = '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_d[k].has_data = 1'b0;
            end
        end else begin
            if (enq) begin
                ent_d[tail_ptr_q].bus      = q.in_bus;
                ent_d[tail_ptr_q].req      = q.in_req;
                ent_d[tail_ptr_q].mem      = q.in_res_from_mem;
                ent_d[tail_ptr_q].op       = q.in_load_op;
                ent_d[tail_ptr_q].result   = q.in_result;
                ent_d[tail_ptr_q].exc      = q.in_exc;
                ent_d[tail_ptr_q].has_data = 1'b0;
                ent_d[tail_ptr_q].data     = '0;
                tail_ptr_d = tail_ptr_q + PW'(1);
            end
            if (deq) begin
                head_ptr_d = head_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
            discard_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
            ent_q      <= ent_d;
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(q.data_ok && (discard_q == '0) && !owed_found));
endmodule

// File: tb/tb_mem_resp_queue.sv
// Self-checking bench for mem_resp_queue: vector table, directed
// corner sequences and a randomized run against a queue model.
module tb_mem_resp_queue;
    localparam int DEPTH = 4;
    localparam int BUS_W = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_resp_queue_if #(.DEPTH(DEPTH), .BUS_W(BUS_W)) ifc ();

    mem_resp_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        mem;
        logic [4:0]  op;
        logic [31:0] res;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [10];

    typedef struct {
        logic        req;
        logic        mem;
        logic [4:0]  op;
        logic [31:0] res;
        logic        exc;
        logic [63:0] bus;
        logic        hd;
        logic [31:0] data;
    } ment_t;
    ment_t mq [$];
    ment_t tmp;
    int    mdisc;
    int    owed;
    logic  e_allow, e_valid, byp, rmem;
    logic [31:0] e_res, e_dat;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic mem, input logic [4:0] op,
                        input logic [31:0] res, input logic exc,
                        input logic [63:0] bus);
        ifc.in_valid        = 1'b1;
        ifc.in_req          = mem;
        ifc.in_res_from_mem = mem;
        ifc.in_load_op      = op;
        ifc.in_result       = res;
        ifc.in_exc          = exc;
        ifc.in_bus          = bus;
    endtask

    function automatic logic [31:0] ref_ext(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] d);
        int     off;
        longint v;
        off = int'(a % 4);
        if (op == 5'd2 || op == 5'd8) begin
            v = longint'((d >> (8 * off)) % 256);
            if (op == 5'd2 && v >= 128) v = v - 256;
        end else if (op == 5'd4 || op == 5'd16) begin
            v = longint'((d >> (16 * (off / 2))) % 65536);
            if (op == 5'd4 && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(d);
        end
        return v[31:0];
    endfunction

    initial begin
        vt[0] = '{1'b1, 5'b00010, 32'h1003, 32'h80FF_FF00, 32'hFFFF_FF80};
        vt[1] = '{1'b1, 5'b01000, 32'h1003, 32'h80FF_FF00, 32'h0000_0080};
        vt[2] = '{1'b1, 5'b10000, 32'h2002, 32'h8001_1234, 32'h0000_8001};
        vt[3] = '{1'b1, 5'b00100, 32'h2002, 32'h8001_1234, 32'hFFFF_8001};
        vt[4] = '{1'b1, 5'b00100, 32'h2000, 32'h8001_1234, 32'h0000_1234};
        vt[5] = '{1'b1, 5'b00001, 32'h3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[6] = '{1'b1, 5'b00010, 32'h4001, 32'h1234_5678, 32'h0000_0056};
        vt[7] = '{1'b1, 5'b00010, 32'h4000, 32'h0000_00F0, 32'hFFFF_FFF0};
        vt[8] = '{1'b1, 5'b01000, 32'h4002, 32'h00AB_0000, 32'h0000_00AB};
        vt[9] = '{1'b0, 5'b00000, 32'h1234_5673, 32'h0, 32'h1234_5673};

        reset = 1'b1;
        ifc.flush = 0; ifc.in_valid = 0; ifc.in_bus = '0;
        ifc.in_req = 0; ifc.in_res_from_mem = 0; ifc.in_load_op = 0;
        ifc.in_result = 0; ifc.in_exc = 0; ifc.out_allowin = 0;
        ifc.data_ok = 0; ifc.rdata = 0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", ifc.out_valid, 0);
        chk("rst_count", ifc.count, 0);
        chk("rst_allowin", ifc.in_allowin, 1);

        // result formation table
        foreach (vt[i]) begin
            push(vt[i].mem, vt[i].op, vt[i].res, 1'b0, 64'(i));
            tick();
            ifc.in_valid = 0;
            if (vt[i].mem) begin
                ifc.data_ok = 1; ifc.rdata = vt[i].rd;
            end
            tick();
            ifc.data_ok = 0; ifc.out_allowin = 1;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), ifc.out_valid, 1);
            chk($sformatf("vec%0d_result", i), ifc.out_result, vt[i].exp);
            chk($sformatf("vec%0d_bus", i), ifc.out_bus, 64'(i));
            tick();
            ifc.out_allowin = 0;
            @(negedge clk);
            chk($sformatf("vec%0d_count", i), ifc.count, 0);
        end

        // single load latency
        tick();
        ifc.out_allowin = 1;
        push(1, 5'b00010, 32'h1003, 0, 64'hA);
        tick();
        ifc.in_valid = 0; ifc.data_ok = 1; ifc.rdata = 32'h80FF_FF00;
        @(negedge clk);
`ifdef MEM_RESP_BYPASS_EN
        chk("lat_byp_valid", ifc.out_valid, 1);
        chk("lat_byp_result", ifc.out_result, 32'hFFFF_FF80);
`else
        chk("lat_wait_valid", ifc.out_valid, 0);
`endif
        tick();
        ifc.data_ok = 0;
        @(negedge clk);
`ifdef MEM_RESP_BYPASS_EN
        chk("lat_byp_count", ifc.count, 0);
`else
        chk("lat_valid", ifc.out_valid, 1);
        chk("lat_result", ifc.out_result, 32'hFFFF_FF80);
`endif
        tick();
        ifc.out_allowin = 0;
        @(negedge clk);
        chk("lat_count", ifc.count, 0);
        tick();

        // non-mem burst into a stalled WB
        for (int i = 1; i <= 4; i++) begin
            push(0, 0, 32'(i), 0, 64'(i));
            @(negedge clk);
            chk("burst_allowin", ifc.in_allowin, 1);
            tick();
        end
        ifc.in_valid = 0;
        @(negedge clk);
        chk("burst_full_allowin", ifc.in_allowin, 0);
        chk("burst_full_count", ifc.count, 4);
        tick(); tick();
        ifc.out_allowin = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("burst_valid", ifc.out_valid, 1);
            chk("burst_result", ifc.out_result, 32'(i));
            tick();
        end
        @(negedge clk);
        chk("burst_empty", ifc.out_valid, 0);
        ifc.out_allowin = 0;
        tick();

        // flush with three owed responses
        for (int i = 0; i < 3; i++) begin
            push(1, 5'b00001, 32'h100 + 32'(4 * i), 0, 64'(i));
            tick();
        end
        ifc.in_valid = 0; ifc.flush = 1;
        @(negedge clk);
        chk("fl_allowin", ifc.in_allowin, 0);
        chk("fl_valid", ifc.out_valid, 0);
        tick();
        ifc.flush = 0;
        @(negedge clk);
        chk("fl_count", ifc.count, 0);
        chk("fl_allowin_after", ifc.in_allowin, 1);
        push(1, 5'b00001, 32'h200, 0, 64'hBEEF);
        tick();
        ifc.in_valid = 0;
        @(negedge clk);
        chk("fl_owed_allowin", ifc.in_allowin, 0);
        repeat (3) begin
            ifc.data_ok = 1; ifc.rdata = 32'h1111_1111;
            tick();
        end
        ifc.data_ok = 0;
        @(negedge clk);
        chk("fl_drop_valid", ifc.out_valid, 0);
        chk("fl_drop_allowin", ifc.in_allowin, 1);
        ifc.data_ok = 1; ifc.rdata = 32'hDEAD_BEEF;
        tick();
        ifc.data_ok = 0; ifc.out_allowin = 1;
        @(negedge clk);
        chk("fl_new_valid", ifc.out_valid, 1);
        chk("fl_new_result", ifc.out_result, 32'hDEAD_BEEF);
        chk("fl_new_bus", ifc.out_bus, 64'hBEEF);
        tick();
        ifc.out_allowin = 0;

        // flush coinciding with data_ok
        for (int i = 0; i < 2; i++) begin
            push(1, 5'b00001, 32'h300, 0, 64'(i));
            tick();
        end
        ifc.in_valid = 0; ifc.flush = 1;
        ifc.data_ok = 1; ifc.rdata = 32'h3333_3333;
        tick();
        ifc.flush = 0; ifc.data_ok = 0;
        @(negedge clk);
        chk("fd_count", ifc.count, 0);
        push(1, 5'b00001, 32'h304, 0, 64'h77);
        tick();
        ifc.in_valid = 0; ifc.data_ok = 1; ifc.rdata = 32'h2222_2222;
        tick();
        ifc.data_ok = 0;
        @(negedge clk);
        chk("fd_drop_valid", ifc.out_valid, 0);
        ifc.data_ok = 1; ifc.rdata = 32'hCAFE_F00D;
        tick();
        ifc.data_ok = 0; ifc.out_allowin = 1;
        @(negedge clk);
        chk("fd_valid", ifc.out_valid, 1);
        chk("fd_result", ifc.out_result, 32'hCAFE_F00D);
        tick();
        ifc.out_allowin = 0;

        // exception entry behind a pending load
        ifc.out_allowin = 1;
        push(1, 5'b00001, 32'h400, 0, 64'h1);
        tick();
        push(0, 0, 32'h77, 1, 64'h2);
        tick();
        ifc.in_valid = 0; ifc.in_exc = 0;
        @(negedge clk);
        chk("exc_wait_valid", ifc.out_valid, 0);
        chk("exc_wait_count", ifc.count, 2);
        tick();
        @(negedge clk);
        chk("exc_wait2_valid", ifc.out_valid, 0);
        ifc.out_allowin = 0; ifc.data_ok = 1; ifc.rdata = 32'h55;
        tick();
        ifc.data_ok = 0; ifc.out_allowin = 1;
        @(negedge clk);
        chk("exc_ld_valid", ifc.out_valid, 1);
        chk("exc_ld_result", ifc.out_result, 32'h55);
        chk("exc_ld_exc", ifc.out_exc, 0);
        tick();
        @(negedge clk);
        chk("exc_valid", ifc.out_valid, 1);
        chk("exc_flag", ifc.out_exc, 1);
        chk("exc_result", ifc.out_result, 32'h77);
        tick();
        ifc.out_allowin = 0;
        @(negedge clk);
        chk("exc_count", ifc.count, 0);

        // reset mid-operation also clears pending discards
        for (int i = 0; i < 3; i++) begin
            push(1, 5'b00001, 32'h500, 0, 64'(i));
            tick();
        end
        ifc.in_valid = 0; ifc.flush = 1;
        tick();
        ifc.flush = 0;
        push(1, 5'b00001, 32'h504, 0, 64'h9);
        tick();
        ifc.in_valid = 0; reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("mrst_count", ifc.count, 0);
        chk("mrst_allowin", ifc.in_allowin, 1);
        push(1, 5'b00001, 32'h508, 0, 64'h5);
        tick();
        ifc.in_valid = 0; ifc.data_ok = 1; ifc.rdata = 32'h600D_F00D;
        tick();
        ifc.data_ok = 0; ifc.out_allowin = 1;
        @(negedge clk);
        chk("mrst_valid", ifc.out_valid, 1);
        chk("mrst_result", ifc.out_result, 32'h600D_F00D);
        tick();
        ifc.out_allowin = 0;
        tick();

        // randomized run against the queue model
        mq.delete();
        mdisc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rmem = 1'($urandom % 2);
            ifc.flush           = ($urandom_range(0, 39) == 0);
            ifc.in_valid        = ($urandom_range(0, 2) != 0);
            ifc.in_req          = rmem;
            ifc.in_res_from_mem = rmem;
            ifc.in_load_op      = rmem ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
            ifc.in_exc          = !rmem && ($urandom_range(0, 7) == 0);
            ifc.in_result       = $urandom;
            ifc.in_bus          = {$urandom, $urandom};
            ifc.out_allowin     = ($urandom_range(0, 3) != 0);
            owed = -1;
            for (int j = mq.size() - 1; j >= 0; j--) begin
                if (mq[j].req && !mq[j].hd) owed = j;
            end
            ifc.data_ok = (mdisc > 0 || owed >= 0) && ($urandom % 2 == 1);
            ifc.rdata   = $urandom;

            e_allow = !ifc.flush && (mq.size() + mdisc < DEPTH);
            byp = 1'b0;
`ifdef MEM_RESP_BYPASS_EN
            byp = ifc.data_ok && mdisc == 0 && owed == 0;
`endif
            e_valid = 1'b0;
            if (mq.size() > 0 && !ifc.flush) begin
                e_valid = !mq[0].req || mq[0].hd || byp;
            end

            @(negedge clk);
            chk("rnd_allowin", ifc.in_allowin, e_allow);
            chk("rnd_valid", ifc.out_valid, e_valid);
            chk("rnd_count", ifc.count, 64'(mq.size()));
            if (e_valid) begin
                e_dat = byp ? ifc.rdata : mq[0].data;
                e_res = mq[0].mem ? ref_ext(mq[0].op, mq[0].res, e_dat)
                                  : mq[0].res;
                chk("rnd_result", ifc.out_result, e_res);
                chk("rnd_exc", ifc.out_exc, mq[0].exc);
                chk("rnd_bus", ifc.out_bus, mq[0].bus);
            end

            if (ifc.data_ok) begin
                if (mdisc > 0) begin
                    mdisc--;
                end else begin
                    tmp = mq[owed];
                    tmp.hd = 1'b1;
                    tmp.data = ifc.rdata;
                    mq[owed] = tmp;
                end
            end
            if (ifc.flush) begin
                foreach (mq[j]) begin
                    if (mq[j].req && !mq[j].hd) mdisc++;
                end
                mq.delete();
            end else begin
                if (e_valid && ifc.out_allowin) void'(mq.pop_front());
                if (ifc.in_valid && e_allow) begin
                    tmp.req  = ifc.in_req;
                    tmp.mem  = ifc.in_res_from_mem;
                    tmp.op   = ifc.in_load_op;
                    tmp.res  = ifc.in_result;
                    tmp.exc  = ifc.in_exc;
                    tmp.bus  = ifc.in_bus;
                    tmp.hd   = 1'b0;
                    tmp.data = '0;
                    mq.push_back(tmp);
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
